// File: rtl/rect_plot_arbiter_pkg.sv
// Shared snake-game definitions for the rectangle plot arbiter.
// Holds the screen size, the requester count, the field widths of a rectangle
// request, the arbiter state encoding and the on-screen test used for clipping.
package rect_plot_arbiter_pkg;

  localparam int NREQ_DEF    = 3;    // 0 = apple draw, 1 = snake draw, 2 = snake erase
  localparam int XSCREEN_DEF = 160;
  localparam int YSCREEN_DEF = 120;

  localparam int X_W   = 8;          // vga_x width
  localparam int Y_W   = 7;          // vga_y width
  localparam int WH_W  = 4;          // rectangle width/height field (0..15)
  localparam int COL_W = 3;          // colour field

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } rect_state_e;

  // The sums are one bit wider than the VGA port, so a pixel past the right or
  // bottom edge is rejected here instead of wrapping onto the opposite side.
  function automatic logic onscreen(input logic [X_W:0] sx,
                                    input logic [Y_W:0] sy,
                                    input int           xs,
                                    input int           ys);
    return (int'(sx) < xs) && (int'(sy) < ys);
  endfunction

endpackage

// File: rtl/rect_plot_arbiter_scan.sv
// Scan counters for one rectangle.
//   UpDn_count : generic loadable up/down counter.
//   rect_scan  : xc (inner) / yc (outer) row-major scan over a w x h rectangle.
//     i_clk, i_rst    clock and synchronous active-high reset
//     i_load          restart the scan at (0,0)
//     i_step          advance one pixel
//     i_w, i_h        rectangle size
//     o_xc, o_yc      current pixel offset
//     o_last          current pixel is the final one (always set for zero area)

module UpDn_count #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Counter register: reset, then load, then count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_up ? (r_count + W'(1)) : (r_count - W'(1));
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

module rect_scan
  import rect_plot_arbiter_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [WH_W-1:0] i_w,
  input  logic [WH_W-1:0] i_h,
  output logic [WH_W-1:0] o_xc,
  output logic [WH_W-1:0] o_yc,
  output logic            o_last
);

  logic w_x_wrap;
  logic w_x_load;
  logic w_y_en;

  // End-of-row detection and the row/column advance controls
  always_comb begin
    w_x_wrap = (o_xc == (i_w - WH_W'(1)));
    w_x_load = i_load | (i_step & w_x_wrap);
    w_y_en   = i_step & w_x_wrap;
    // A zero-sized rectangle is "last" immediately so DRAW lasts a single cycle.
    if ((i_w == {WH_W{1'b0}}) || (i_h == {WH_W{1'b0}})) begin
      o_last = 1'b1;
    end else begin
      o_last = w_x_wrap && (o_yc == (i_h - WH_W'(1)));
    end
  end

  UpDn_count #(.W(WH_W)) u_xc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_x_load),
    .i_load_val ({WH_W{1'b0}}),
    .i_en       (i_step),
    .i_up       (1'b1),
    .o_count    (o_xc)
  );

  UpDn_count #(.W(WH_W)) u_yc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (i_load),
    .i_load_val ({WH_W{1'b0}}),
    .i_en       (w_y_en),
    .i_up       (1'b1),
    .o_count    (o_yc)
  );

endmodule

// File: rtl/rect_plot_arbiter.sv
// Round-robin arbiter that lets several requesters draw filled rectangles
// through a single vga_adapter pixel port, one pixel per clock.
//   CLOCK_50, Reset          clock, synchronous active-high reset
//   req                      per-requester level request (held until gnt)
//   req_x/y/w/h/colour       packed per-requester rectangle fields
//   gnt                      one-hot pulse in the IDLE cycle that captures a request
//   done                     one-hot pulse in the DONE cycle of that rectangle
//   busy                     high outside IDLE
//   vga_x, vga_y, vga_colour, plot   pixel write port
module rect_plot_arbiter
  import rect_plot_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int XSCREEN = XSCREEN_DEF,
  parameter int YSCREEN = YSCREEN_DEF
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*X_W-1:0]   req_x,
  input  logic [NREQ*Y_W-1:0]   req_y,
  input  logic [NREQ*WH_W-1:0]  req_w,
  input  logic [NREQ*WH_W-1:0]  req_h,
  input  logic [NREQ*COL_W-1:0] req_colour,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [X_W-1:0]        vga_x,
  output logic [Y_W-1:0]        vga_y,
  output logic [COL_W-1:0]      vga_colour,
  output logic                  plot
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  rect_state_e      r_state;
  rect_state_e      w_state_nxt;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] r_sel;
  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_grant;
  logic             w_step;
  logic             w_scan_last;

  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [WH_W-1:0]  r_w;
  logic [WH_W-1:0]  r_h;
  logic [COL_W-1:0] r_col;

  logic [X_W-1:0]   w_cap_x;
  logic [Y_W-1:0]   w_cap_y;
  logic [WH_W-1:0]  w_cap_w;
  logic [WH_W-1:0]  w_cap_h;
  logic [COL_W-1:0] w_cap_col;

  logic [WH_W-1:0]  w_xc;
  logic [WH_W-1:0]  w_yc;
  logic [X_W:0]     w_sum_x;
  logic [Y_W:0]     w_sum_y;
  logic             w_vis;

  // Round-robin pick: the first requesting index after r_last, circularly.
  // Walking the offsets downwards lets the nearest one overwrite the others.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    v_idx  = r_last;
    w_any  = 1'b0;
    w_pick = r_last;
    for (int k = NREQ; k >= 1; k--) begin
      v_idx = IDX_W'((int'(r_last) + k) % NREQ);
      if (req[v_idx]) begin
        w_any  = 1'b1;
        w_pick = v_idx;
      end else begin
      end
    end
  end

  // Field multiplexer for the picked requester
  always_comb begin
    w_cap_x   = {X_W{1'b0}};
    w_cap_y   = {Y_W{1'b0}};
    w_cap_w   = {WH_W{1'b0}};
    w_cap_h   = {WH_W{1'b0}};
    w_cap_col = {COL_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_cap_x   = req_x[i*X_W +: X_W];
        w_cap_y   = req_y[i*Y_W +: Y_W];
        w_cap_w   = req_w[i*WH_W +: WH_W];
        w_cap_h   = req_h[i*WH_W +: WH_W];
        w_cap_col = req_colour[i*COL_W +: COL_W];
      end else begin
      end
    end
  end

  // Next-state logic: grant from IDLE, scan in DRAW, single-cycle DONE
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_DRAW;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (w_scan_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_step      = 1'b1;
          w_state_nxt = ST_DRAW;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, round-robin pointer and captured rectangle registers
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_last  <= IDX_W'(NREQ - 1);
      r_sel   <= {IDX_W{1'b0}};
      r_x     <= {X_W{1'b0}};
      r_y     <= {Y_W{1'b0}};
      r_w     <= {WH_W{1'b0}};
      r_h     <= {WH_W{1'b0}};
      r_col   <= {COL_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last <= w_pick;
        r_sel  <= w_pick;
        r_x    <= w_cap_x;
        r_y    <= w_cap_y;
        r_w    <= w_cap_w;
        r_h    <= w_cap_h;
        r_col  <= w_cap_col;
      end else begin
        r_last <= r_last;
        r_sel  <= r_sel;
        r_x    <= r_x;
        r_y    <= r_y;
        r_w    <= r_w;
        r_h    <= r_h;
        r_col  <= r_col;
      end
    end
  end

  rect_scan u_scan (
    .i_clk  (CLOCK_50),
    .i_rst  (Reset),
    .i_load (w_grant),
    .i_step (w_step),
    .i_w    (r_w),
    .i_h    (r_h),
    .o_xc   (w_xc),
    .o_yc   (w_yc),
    .o_last (w_scan_last)
  );

  // Pixel address, clip test and status outputs; all outputs held low during Reset
  always_comb begin
    w_sum_x    = {1'b0, r_x} + {{(X_W + 1 - WH_W){1'b0}}, w_xc};
    w_sum_y    = {1'b0, r_y} + {{(Y_W + 1 - WH_W){1'b0}}, w_yc};
    w_vis      = onscreen(w_sum_x, w_sum_y, XSCREEN, YSCREEN) &&
                 (r_w != {WH_W{1'b0}}) && (r_h != {WH_W{1'b0}});
    gnt        = {NREQ{1'b0}};
    done       = {NREQ{1'b0}};
    busy       = 1'b0;
    vga_x      = {X_W{1'b0}};
    vga_y      = {Y_W{1'b0}};
    vga_colour = {COL_W{1'b0}};
    plot       = 1'b0;
    if (!Reset) begin
      gnt        = w_grant ? (NREQ'(1) << w_pick) : {NREQ{1'b0}};
      done       = (r_state == ST_DONE) ? (NREQ'(1) << r_sel) : {NREQ{1'b0}};
      busy       = (r_state != ST_IDLE);
      vga_x      = w_sum_x[X_W-1:0];
      vga_y      = w_sum_y[Y_W-1:0];
      vga_colour = r_col;
      plot       = (r_state == ST_DRAW) && w_vis;
    end else begin
      plot = 1'b0;
    end
  end

endmodule
